// File: rtl/isa_pkg.sv
// Shared fetch-side definitions: FSM state encoding, word/address types and
// the default halt encoding used by fetch_sequencer.
package isa_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  localparam word_t DEFAULT_HALT_WORD = 16'hFFFF;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers each fetched word with
// its PC for decode, handles redirects, halt words and out-of-range faults.
// Optional macro FETCH_PERF_EN adds the fetch_count transfer counter port.
module fetch_sequencer
  import isa_pkg::*;
#(
  parameter int    MEM_DEPTH = 16,
  parameter addr_t RESET_PC  = 16'h0000,
  parameter word_t HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic         clk,
  input  logic         reset,
  output addr_t        imem_adr,
  input  word_t        imem_data,
  output word_t        instr,
  output addr_t        instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  addr_t        redirect_target,
  output logic         halted,
  output logic         fault,
  output fetch_state_e dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  fetch_count
`endif
);

  // Handshake: a word moves to decode on any rising edge where instr_valid
  // and instr_ready are both high; while valid and not ready it holds stable.
  localparam addr_t LAST_PC = addr_t'(MEM_DEPTH - 1);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  addr_t        instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;

  logic xfer;
  logic slot_free;
  logic pc_in_range;

  assign xfer        = instr_valid_q && instr_ready;
  assign slot_free   = !instr_valid_q || instr_ready;
  assign pc_in_range = (pc_q <= LAST_PC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    if (redirect_valid) begin
      // A coincident transfer still completes; the held word is simply dropped.
      state_d       = RUN;
      pc_d          = redirect_target;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
      fault_d       = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (slot_free) begin
            if (pc_in_range) begin
              instr_d       = imem_data;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
              if (imem_data == HALT_WORD) begin
                state_d = DRAIN;
              end else begin
                pc_d = pc_q + 16'd1;
              end
            end else begin
              instr_valid_d = 1'b0;
              fault_d       = 1'b1;
              state_d       = FAULT;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = HALTED;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    imem_adr    = pc_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    instr_valid = instr_valid_q;
    halted      = halted_q;
    fault       = fault_q;
    dbg_state   = state_q;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Saturating transfer count; survives redirects, cleared only by reset.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (xfer && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes the expected delivered
// stream {pc, word}; a negedge monitor compares every presented word against it.
module tb_fetch_sequencer;
  import isa_pkg::*;

  localparam int          W    = 32;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic         clk;
  logic         reset;
  addr_t        imem_adr;
  word_t        imem_data;
  word_t        instr;
  addr_t        instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect_valid;
  addr_t        redirect_target;
  logic         halted;
  logic         fault;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0]  fetch_count;
`endif

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .imem_adr        (imem_adr),
    .imem_data       (imem_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fault           (fault),
    .dbg_state       (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [16];
  assign imem_data = (imem_adr < 16'd16) ? mem[imem_adr[3:0]] : 16'hDEAD;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_fail;
  int           model_count;
  bit           exp_halt_next;
  bit           exp_fault_next;
  logic [15:0]  last_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Expected stream from a start PC: sequential words until a halt word
  // (inclusive) or the end of memory, beyond which fetch faults.
  task automatic push_seq(input logic [15:0] start);
    for (int p = int'(start); p < 16; p++) begin
      exp_q.push_back({16'(p), mem[p]});
      if (mem[p] == HALT) break;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
    end
  endtask

  task automatic do_reset(input bit with_redirect);
    reset           = 1'b1;
    redirect_valid  = with_redirect;
    redirect_target = 16'h0008;
    cycle();
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_adr", 32'(imem_adr), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
    cycle();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    exp_halt_next  = 1'b0;
    exp_fault_next = 1'b0;
    model_count    = 0;
    push_seq(16'h0000);
    @(negedge clk);
    check("first_cycle_valid_low", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("second_cycle_valid_high", 32'(instr_valid), 32'd1);
    cycle();
  endtask

  // Bubble: valid low in n+1, target word (or fault) in n+2.
  task automatic do_redirect(input logic [15:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    cycle();
    redirect_valid = 1'b0;
    exp_q.delete();
    exp_halt_next  = 1'b0;
    exp_fault_next = 1'b0;
    push_seq(target);
    @(negedge clk);
    check("redirect_bubble_valid", 32'(instr_valid), 32'd0);
    check("redirect_clears_halted", 32'(halted), 32'd0);
    check("redirect_clears_fault", 32'(fault), 32'd0);
    @(negedge clk);
    if (target < 16'd16) begin
      check("redirect_target_valid", 32'(instr_valid), 32'd1);
      check("redirect_target_pc", 32'(instr_pc), 32'(target));
    end else begin
      check("redirect_oob_fault", 32'(fault), 32'd1);
      check("redirect_oob_valid", 32'(instr_valid), 32'd0);
    end
    cycle();
  endtask

  task automatic expect_idle(input bit exp_h, input bit exp_f);
    check("idle_queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_halted", 32'(halted), 32'(exp_h));
    check("idle_fault", 32'(fault), 32'(exp_f));
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_state", 32'(dbg_state), exp_h ? 32'(HALTED) : 32'(FAULT));
`ifdef FETCH_PERF_EN
    check("fetch_count", 32'(fetch_count), 32'(model_count));
`endif
  endtask

  // Monitor: every presented word must be the scoreboard head; status flags
  // follow one cycle after the last word of a stream transfers.
  logic [W-1:0] front;
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_halt_next) begin
        check("halted_rise", 32'(halted), 32'd1);
        check("halted_valid_low", 32'(instr_valid), 32'd0);
        check("halted_adr", 32'(imem_adr), 32'(last_pc));
      end
      if (exp_fault_next) begin
        check("fault_rise", 32'(fault), 32'd1);
        check("fault_valid_low", 32'(instr_valid), 32'd0);
        check("fault_adr", 32'(imem_adr), 32'(16'(last_pc + 16'd1)));
      end
      exp_halt_next  = 1'b0;
      exp_fault_next = 1'b0;
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {instr_pc, instr}, 32'hxxxx_xxxx);
        end else begin
          front = exp_q[0];
          check("word_pc", 32'(instr_pc), 32'(front[31:16]));
          check("word_data", 32'(instr), 32'(front[15:0]));
          check("word_adr", 32'(imem_adr),
                (front[15:0] == HALT) ? 32'(front[31:16]) : 32'(16'(front[31:16] + 16'd1)));
          if (instr_ready) begin
            void'(exp_q.pop_front());
            model_count++;
            last_pc = front[31:16];
            if (front[15:0] == HALT) exp_halt_next = 1'b1;
            else if (exp_q.size() == 0) exp_fault_next = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] tgt;
    int          r;
    n_cmp           = 0;
    n_fail          = 0;
    model_count     = 0;
    exp_halt_next   = 1'b0;
    exp_fault_next  = 1'b0;
    last_pc         = '0;
    reset           = 1'b1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h2000 + 16'(i);
    mem[0] = 16'h1001;
    mem[1] = 16'h1002;
    mem[2] = 16'h1003;
    mem[3] = 16'h1004;
    mem[5] = HALT;

    // Directed: stream, stall on PC 2, redirect drop, fault past 15, halt.
    do_reset(1'b0);
    cycle();
    instr_ready = 1'b0;
    repeat (3) cycle();
    instr_ready = 1'b1;
    cycle();
    cycle();
    instr_ready = 1'b0;
    do_redirect(16'h0008);
    instr_ready = 1'b1;
    repeat (12) cycle();
    expect_idle(1'b0, 1'b1);
    do_redirect(16'h0004);
    repeat (6) cycle();
    expect_idle(1'b1, 1'b0);
    do_redirect(16'h0000);
    repeat (10) cycle();
    expect_idle(1'b1, 1'b0);
    instr_ready = 1'b0;
    do_reset(1'b1);

    // Randomized traffic.
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        randomize_mem();
        instr_ready = ($urandom_range(0, 1) == 1);
        do_reset($urandom_range(0, 1) == 1);
      end else if (r < 10) begin
        tgt = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16, 40)) : 16'($urandom_range(0, 15));
        do_redirect(tgt);
      end else begin
        instr_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    instr_ready = 1'b1;
    repeat (20) cycle();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    check("final_fetch_count", 32'(fetch_count), 32'(model_count));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
